// File: rtl/openmips_defs.sv
// openmips_defs: shared widths, reset/enable polarity and reset constants for the fetch front end
package openmips_defs;
    localparam int InstBus = 32;
    localparam int InstAddrBus = 32;
    localparam logic [InstBus-1:0] NOP_INST = 32'h0;
    localparam logic [InstAddrBus-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic RstEnable = 1'b0;
    localparam logic RstDisable = 1'b1;
    localparam logic ChipEnable = 1'b1;
    localparam logic ChipDisable = 1'b0;
endpackage

// File: rtl/openmips_if_stage_if.sv
// openmips_if_stage_if: ROM, decode and redirect signals of the fetch stage
//   master: fetch stage (drives ROM address/enable and the IF/ID pair)
//   slave : environment (ROM data, ID stall, execute-side branch redirect)
interface openmips_if_stage_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    logic [ADDR_W-1:0] rom_addr_o;
    logic              rom_ce_o;
    logic [INST_W-1:0] rom_data_i;
    logic              stall_i;
    logic              branch_i;
    logic [ADDR_W-1:0] branch_target_i;
    logic [ADDR_W-1:0] if_pc_o;
    logic [INST_W-1:0] if_inst_o;
    logic              if_valid_o;
    modport master (
        output rom_addr_o, rom_ce_o, if_pc_o, if_inst_o, if_valid_o,
        input  rom_data_i, stall_i, branch_i, branch_target_i
    );
    modport slave (
        input  rom_addr_o, rom_ce_o, if_pc_o, if_inst_o, if_valid_o,
        output rom_data_i, stall_i, branch_i, branch_target_i
    );
endinterface

// File: rtl/openmips_fetch_fifo.sv
// openmips_fetch_fifo: prefetch FIFO holding {pc, inst} pairs
//   clk/rst: core clock, async active-low reset
//   clr: synchronous flush (wins over push/pop); push/wdata, pop/rdata; full, empty
module openmips_fetch_fifo
    import openmips_defs::*;
#(
    parameter int DEPTH = 2,
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic          push_ok, pop_ok;
    assign full  = count_q == (AW+1)'(DEPTH);
    assign empty = count_q == '0;
    assign rdata = mem_q[rd_ptr_q];
    always_comb begin
        push_ok  = push & !full & !clr;
        pop_ok   = pop & !empty & !clr;
        wr_ptr_d = clr ? '0 : wr_ptr_q + AW'(push_ok);
        rd_ptr_d = clr ? '0 : rd_ptr_q + AW'(pop_ok);
        count_d  = clr ? '0 : count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
    // Storage needs no reset: an empty count hides stale words.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end
endmodule

// File: rtl/openmips_if_stage.sv
// openmips_if_stage: instruction fetch with PC, ROM enable, prefetch FIFO and IF/ID register
//   clk/rst: core clock, async active-low reset
//   bus (master): rom_addr_o/rom_ce_o/rom_data_i to ROM, stall_i from ID,
//                 branch_i/branch_target_i redirect, if_pc_o/if_inst_o/if_valid_o to ID
module openmips_if_stage
    import openmips_defs::*;
#(
    parameter int INST_W = InstBus,
    parameter int ADDR_W = InstAddrBus,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
    parameter int FIFO_DEPTH = 2
) (
    input logic clk,
    input logic rst,
    openmips_if_stage_if.master bus
);
    logic              ce_q, ce_d;
    logic [ADDR_W-1:0] pc_q, pc_d, if_pc_q, if_pc_d, head_pc;
    logic [INST_W-1:0] if_inst_q, if_inst_d, head_inst;
    logic              if_valid_q, if_valid_d;
    logic              full, empty, fetch, issue, pop;
    openmips_fetch_fifo #(.DEPTH(FIFO_DEPTH), .W(ADDR_W + INST_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.branch_i),
        .push  (fetch),
        .pop   (pop),
        .wdata ({pc_q, bus.rom_data_i}),
        .rdata ({head_pc, head_inst}),
        .full  (full),
        .empty (empty)
    );
    always_comb begin
        fetch      = ce_q & !full & !bus.branch_i;
        issue      = !bus.stall_i | !if_valid_q;
        pop        = issue & !empty & !bus.branch_i;
        ce_d       = ChipEnable;
        pc_d       = !ce_q ? pc_q :
                     bus.branch_i ? {bus.branch_target_i[ADDR_W-1:2], 2'b00} :
                     fetch ? pc_q + ADDR_W'(4) : pc_q;
        if_pc_d    = pop ? head_pc : if_pc_q;
        // Branch and empty-issue both present a NOP bubble; otherwise hold.
        if_inst_d  = pop ? head_inst : (bus.branch_i | issue) ? INST_W'(NOP_INST) : if_inst_q;
        if_valid_d = pop | (!(bus.branch_i | issue) & if_valid_q);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            ce_q       <= ChipDisable;
            pc_q       <= RESET_PC;
            if_pc_q    <= '0;
            if_inst_q  <= INST_W'(NOP_INST);
            if_valid_q <= 1'b0;
        end else begin
            ce_q       <= ce_d;
            pc_q       <= pc_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
            if_valid_q <= if_valid_d;
        end
    end
    assign bus.rom_addr_o = pc_q;
    assign bus.rom_ce_o   = ce_q;
    assign bus.if_pc_o    = if_pc_q;
    assign bus.if_inst_o  = if_inst_q;
    assign bus.if_valid_o = if_valid_q;
endmodule

// File: tb/tb_openmips_if_stage.sv
// tb_openmips_if_stage: directed vector table, wrap instance, random stall/branch run, async reset
module tb_openmips_if_stage;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int total = 0;
    int bad = 0;
    always #5 clk = ~clk;

    openmips_if_stage_if bus ();
    openmips_if_stage_if wbus ();

    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    assign bus.rom_data_i  = rom(bus.rom_addr_o);
    assign wbus.rom_data_i = rom(wbus.rom_addr_o);

    openmips_if_stage #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    openmips_if_stage #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) wdut (
        .clk(clk), .rst(rst), .bus(wbus)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] addr;
        logic        v;
        logic [31:0] pc;
        logic [31:0] inst;
    } vec_t;
    vec_t tbl [25];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_pc, pp, pi, wa;
        logic        pv, s, b;
        logic [31:0] t;
        int          clean;
        tbl[0]  = '{1'b0, 1'b0, 32'h0,  32'h00, 1'b0, 32'h00, 32'h0};
        tbl[1]  = '{1'b0, 1'b0, 32'h0,  32'h04, 1'b0, 32'h00, 32'h0};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,  32'h08, 1'b1, 32'h00, 32'h1000_0000};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,  32'h0C, 1'b1, 32'h04, 32'h1000_0001};
        tbl[4]  = '{1'b0, 1'b0, 32'h0,  32'h10, 1'b1, 32'h08, 32'h1000_0002};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,  32'h14, 1'b1, 32'h0C, 32'h1000_0003};
        for (int i = 6; i < 11; i++)
            tbl[i] = '{1'b1, 1'b0, 32'h0, 32'h18, 1'b1, 32'h0C, 32'h1000_0003};
        tbl[11] = '{1'b0, 1'b0, 32'h0,  32'h18, 1'b1, 32'h10, 32'h1000_0004};
        tbl[12] = '{1'b0, 1'b0, 32'h0,  32'h1C, 1'b1, 32'h14, 32'h1000_0005};
        tbl[13] = '{1'b0, 1'b0, 32'h0,  32'h20, 1'b1, 32'h18, 32'h1000_0006};
        tbl[14] = '{1'b0, 1'b0, 32'h0,  32'h24, 1'b1, 32'h1C, 32'h1000_0007};
        tbl[15] = '{1'b0, 1'b1, 32'h40, 32'h40, 1'b0, 32'h1C, 32'h0};
        tbl[16] = '{1'b0, 1'b0, 32'h0,  32'h44, 1'b0, 32'h1C, 32'h0};
        tbl[17] = '{1'b0, 1'b0, 32'h0,  32'h48, 1'b1, 32'h40, 32'h1000_0010};
        tbl[18] = '{1'b0, 1'b0, 32'h0,  32'h4C, 1'b1, 32'h44, 32'h1000_0011};
        tbl[19] = '{1'b1, 1'b0, 32'h0,  32'h50, 1'b1, 32'h44, 32'h1000_0011};
        tbl[20] = '{1'b1, 1'b0, 32'h0,  32'h50, 1'b1, 32'h44, 32'h1000_0011};
        tbl[21] = '{1'b1, 1'b1, 32'h83, 32'h80, 1'b0, 32'h44, 32'h0};
        tbl[22] = '{1'b0, 1'b0, 32'h0,  32'h84, 1'b0, 32'h44, 32'h0};
        tbl[23] = '{1'b0, 1'b0, 32'h0,  32'h88, 1'b1, 32'h80, 32'h1000_0020};
        tbl[24] = '{1'b0, 1'b0, 32'h0,  32'h8C, 1'b1, 32'h84, 32'h1000_0021};

        bus.stall_i = 1'b0; bus.branch_i = 1'b0; bus.branch_target_i = '0;
        wbus.stall_i = 1'b0; wbus.branch_i = 1'b0; wbus.branch_target_i = '0;

        #30;
        chk("rst_ce", {31'b0, bus.rom_ce_o}, 32'h0);
        chk("rst_addr", bus.rom_addr_o, 32'h0);
        chk("rst_valid", {31'b0, bus.if_valid_o}, 32'h0);
        chk("rst_pc", bus.if_pc_o, 32'h0);
        chk("rst_inst", bus.if_inst_o, 32'h0);
        chk("rst_waddr", wbus.rom_addr_o, 32'hFFFF_FFF8);
        #43 rst = 1'b1;

        for (int i = 0; i < 25; i++) begin
            bus.stall_i = tbl[i].stall;
            bus.branch_i = tbl[i].br;
            bus.branch_target_i = tbl[i].tgt;
            @(posedge clk); #1;
            chk($sformatf("v%0d_ce", i), {31'b0, bus.rom_ce_o}, 32'h1);
            chk($sformatf("v%0d_addr", i), bus.rom_addr_o, tbl[i].addr);
            chk($sformatf("v%0d_valid", i), {31'b0, bus.if_valid_o}, {31'b0, tbl[i].v});
            chk($sformatf("v%0d_pc", i), bus.if_pc_o, tbl[i].pc);
            chk($sformatf("v%0d_inst", i), bus.if_inst_o, tbl[i].inst);
            if (i < 6) begin
                wa = 32'hFFFF_FFF8 + 32'(4 * i);
                chk($sformatf("wrap%0d_addr", i), wbus.rom_addr_o, wa);
                if (i >= 2) begin
                    wa = 32'hFFFF_FFF8 + 32'(4 * (i - 2));
                    chk($sformatf("wrap%0d_pc", i), wbus.if_pc_o, wa);
                    chk($sformatf("wrap%0d_inst", i), wbus.if_inst_o, rom(wa));
                end
            end
        end

        // Random run: the consumed stream must be program order from the last
        // redirect, every word matching the ROM, with holds under stall.
        bus.stall_i = 1'b0; bus.branch_i = 1'b0;
        exp_pc = 32'h84;
        clean = 0;
        for (int n = 0; n < 400; n++) begin
            s = ($urandom_range(0, 9) < 3);
            b = ($urandom_range(0, 15) == 0);
            t = $urandom & 32'h0000_3FFF;
            bus.stall_i = s; bus.branch_i = b; bus.branch_target_i = t;
            pv = bus.if_valid_o; pp = bus.if_pc_o; pi = bus.if_inst_o;
            @(posedge clk); #1;
            if (b) begin
                chk("rnd_br_valid", {31'b0, bus.if_valid_o}, 32'h0);
                chk("rnd_br_addr", bus.rom_addr_o, {t[31:2], 2'b00});
                exp_pc = {t[31:2], 2'b00};
                clean = 0;
            end else begin
                if (pv && !s) begin
                    chk("rnd_pc", pp, exp_pc);
                    chk("rnd_inst", pi, rom(exp_pc));
                    exp_pc = exp_pc + 32'd4;
                end
                if (pv && s) begin
                    chk("rnd_hold_pc", bus.if_pc_o, pp);
                    chk("rnd_hold_inst", bus.if_inst_o, pi);
                    chk("rnd_hold_valid", {31'b0, bus.if_valid_o}, 32'h1);
                end
                clean = s ? 0 : clean + 1;
                if (clean >= 3) chk("rnd_live", {31'b0, bus.if_valid_o}, 32'h1);
            end
        end

        bus.stall_i = 1'b0; bus.branch_i = 1'b0;
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        chk("arst_ce", {31'b0, bus.rom_ce_o}, 32'h0);
        chk("arst_addr", bus.rom_addr_o, 32'h0);
        chk("arst_valid", {31'b0, bus.if_valid_o}, 32'h0);
        chk("arst_pc", bus.if_pc_o, 32'h0);
        chk("arst_inst", bus.if_inst_o, 32'h0);
        chk("arst_waddr", wbus.rom_addr_o, 32'hFFFF_FFF8);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        chk("rel1_ce", {31'b0, bus.rom_ce_o}, 32'h1);
        chk("rel1_addr", bus.rom_addr_o, 32'h0);
        @(posedge clk); #1;
        chk("rel2_valid", {31'b0, bus.if_valid_o}, 32'h0);
        chk("rel2_addr", bus.rom_addr_o, 32'h4);
        @(posedge clk); #1;
        chk("rel3_valid", {31'b0, bus.if_valid_o}, 32'h1);
        chk("rel3_pc", bus.if_pc_o, 32'h0);
        chk("rel3_inst", bus.if_inst_o, 32'h1000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
